// File: rtl/core_mem_stage_pkg.sv
// Shared constants and types for the memory stage: RV32 opcodes, load/store
// width encodings and the load/store access FSM state type.
package core_mem_stage_pkg;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_R      = 7'b0110011;
  localparam logic [6:0] OPCODE_I      = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  // Processing-in-memory extension lives in the custom-0 opcode slot.
  localparam logic [6:0] OPCODE_PIM    = 7'b0001011;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    WAIT_GNT    = 2'd1,
    WAIT_RVALID = 2'd2
  } mem_state_e;

  function automatic logic writes_rd(input logic [6:0] opcode);
    case (opcode)
      OPCODE_R, OPCODE_I, OPCODE_LOAD, OPCODE_LUI, OPCODE_AUIPC,
      OPCODE_JAL, OPCODE_JALR, OPCODE_PIM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/core_mem_stage_lsu_align.sv
// Combinational load/store alignment: store byte lanes and enables, access
// legality checking, and load byte/half extraction with extension.
module lsu_align
  import core_mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            is_load_i,
  input  logic            is_store_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [1:0]      req_offset_i,
  input  logic [XLEN-1:0] store_data_i,
  output logic [3:0]      be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic            misaligned_o,
  input  logic [2:0]      ld_funct3_i,
  input  logic [1:0]      ld_offset_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] load_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be_o         = 4'b0000;
    wdata_o      = store_data_i;
    misaligned_o = 1'b0;
    if (is_store_i) begin
      case (req_funct3_i)
        F3_B: begin
          be_o    = 4'b0001 << req_offset_i;
          wdata_o = {4{store_data_i[7:0]}};
        end
        F3_H: begin
          be_o         = 4'b0011 << {req_offset_i[1], 1'b0};
          wdata_o      = {2{store_data_i[15:0]}};
          misaligned_o = req_offset_i[0];
        end
        F3_W: begin
          be_o         = 4'b1111;
          misaligned_o = |req_offset_i;
        end
        default: misaligned_o = 1'b1;
      endcase
    end else if (is_load_i) begin
      // Loads also present lane enables so the memory can gate its read port.
      case (req_funct3_i)
        F3_B, F3_BU: be_o = 4'b0001 << req_offset_i;
        F3_H, F3_HU: begin
          be_o         = 4'b0011 << {req_offset_i[1], 1'b0};
          misaligned_o = req_offset_i[0];
        end
        F3_W: begin
          be_o         = 4'b1111;
          misaligned_o = |req_offset_i;
        end
        default: misaligned_o = 1'b1;
      endcase
    end
  end

  always_comb begin
    case (ld_offset_i)
      2'd0:    ld_byte = rdata_i[7:0];
      2'd1:    ld_byte = rdata_i[15:8];
      2'd2:    ld_byte = rdata_i[23:16];
      default: ld_byte = rdata_i[31:24];
    endcase
    ld_half = ld_offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (ld_funct3_i)
      F3_B:    load_data_o = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_BU:   load_data_o = {{(XLEN-8){1'b0}}, ld_byte};
      F3_H:    load_data_o = {{(XLEN-16){ld_half[15]}}, ld_half};
      F3_HU:   load_data_o = {{(XLEN-16){1'b0}}, ld_half};
      default: load_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/core_mem_stage.sv
// RV32IM memory stage: data-memory access FSM over req/gnt/rvalid, result
// selection and the MEM/WB pipeline register.
module core_mem_stage
  import core_mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [6:0]      opcode_i,
  input  logic [2:0]      funct3_i,
  input  logic [6:0]      funct7_i,
  input  logic [4:0]      rd_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [XLEN-1:0] mul_result_i,
  output logic            stall_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            wb_valid_o,
  output logic [4:0]      wb_rd_o,
  output logic            wb_reg_write_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            misaligned_o
);

  mem_state_e state_q, state_d;

  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic            we_q, we_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [1:0]      offset_q, offset_d;
  logic [4:0]      rd_q, rd_d;

  logic            wb_valid_q, wb_reg_write_q, misaligned_q;
  logic [4:0]      wb_rd_q;
  logic [XLEN-1:0] wb_data_q;

  logic            is_load, is_store, is_mem;
  logic [3:0]      lsu_be;
  logic [XLEN-1:0] lsu_wdata, load_data;
  logic            lsu_misaligned;
  logic [XLEN-1:0] addr_word;
  logic [XLEN-1:0] nonmem_data;

  logic            retire;
  logic            ret_write;
  logic            ret_mis;
  logic [4:0]      ret_rd;
  logic [XLEN-1:0] ret_data;

  assign is_load   = (opcode_i == OPCODE_LOAD);
  assign is_store  = (opcode_i == OPCODE_STORE);
  assign is_mem    = is_load | is_store;
  assign addr_word = {alu_result_i[XLEN-1:2], 2'b00};

  lsu_align #(.XLEN(XLEN)) u_lsu_align (
    .is_load_i    (is_load),
    .is_store_i   (is_store),
    .req_funct3_i (funct3_i),
    .req_offset_i (alu_result_i[1:0]),
    .store_data_i (store_data_i),
    .be_o         (lsu_be),
    .wdata_o      (lsu_wdata),
    .misaligned_o (lsu_misaligned),
    .ld_funct3_i  (funct3_q),
    .ld_offset_i  (offset_q),
    .rdata_i      (dmem_rdata_i),
    .load_data_o  (load_data)
  );

  always_comb begin
    if (opcode_i == OPCODE_JAL || opcode_i == OPCODE_JALR) begin
      nonmem_data = pc_i + XLEN'(4);
    end else if (opcode_i == OPCODE_R && funct7_i == FUNCT7_MULDIV) begin
      nonmem_data = mul_result_i;
    end else begin
      nonmem_data = alu_result_i;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    offset_d     = offset_q;
    rd_d         = rd_q;
    stall_o      = 1'b0;
    dmem_req_o   = 1'b0;
    dmem_we_o    = we_q;
    dmem_be_o    = be_q;
    dmem_addr_o  = addr_q;
    dmem_wdata_o = wdata_q;
    retire       = 1'b0;
    ret_write    = 1'b0;
    ret_mis      = 1'b0;
    ret_rd       = rd_q;
    ret_data     = alu_result_i;

    case (state_q)
      IDLE: begin
        dmem_we_o    = is_store;
        dmem_be_o    = lsu_be;
        dmem_addr_o  = addr_word;
        dmem_wdata_o = lsu_wdata;
        ret_rd       = rd_i;
        if (ex_valid_i) begin
          if (!is_mem) begin
            retire    = 1'b1;
            ret_write = writes_rd(opcode_i) && (rd_i != 5'd0);
            ret_data  = nonmem_data;
          end else if (lsu_misaligned) begin
            // Illegal access retires as a non-writing instruction with a flag.
            retire  = 1'b1;
            ret_mis = 1'b1;
          end else begin
            dmem_req_o = 1'b1;
            addr_d     = addr_word;
            wdata_d    = lsu_wdata;
            be_d       = lsu_be;
            we_d       = is_store;
            funct3_d   = funct3_i;
            offset_d   = alu_result_i[1:0];
            rd_d       = rd_i;
            if (is_store && dmem_gnt_i) begin
              retire = 1'b1;
            end else begin
              stall_o = 1'b1;
              state_d = dmem_gnt_i ? WAIT_RVALID : WAIT_GNT;
            end
          end
        end
      end

      WAIT_GNT: begin
        dmem_req_o = 1'b1;
        stall_o    = 1'b1;
        if (dmem_gnt_i) begin
          if (we_q) begin
            stall_o = 1'b0;
            retire  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_RVALID;
          end
        end
      end

      WAIT_RVALID: begin
        stall_o = 1'b1;
        if (dmem_rvalid_i) begin
          stall_o   = 1'b0;
          retire    = 1'b1;
          ret_write = (rd_q != 5'd0);
          ret_data  = load_data;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      we_q     <= 1'b0;
      funct3_q <= '0;
      offset_q <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      offset_q <= offset_d;
      rd_q     <= rd_d;
    end
  end

  // MEM/WB register: valid and write-enable collapse to 0 on bubble cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      misaligned_q   <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
    end else begin
      wb_valid_q     <= retire;
      wb_reg_write_q <= retire & ret_write;
      misaligned_q   <= retire & ret_mis;
      if (retire) begin
        wb_rd_q   <= ret_rd;
        wb_data_q <= ret_data;
      end
    end
  end

  assign wb_valid_o     = wb_valid_q;
  assign wb_reg_write_o = wb_reg_write_q;
  assign misaligned_o   = misaligned_q;
  assign wb_rd_o        = wb_rd_q;
  assign wb_data_o      = wb_data_q;

endmodule

// File: tb/tb_core_mem_stage.sv
// Self-checking bench for core_mem_stage: directed scenarios followed by
// randomized operations checked against an arithmetic reference model.
module tb_core_mem_stage;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_PIM    = 7'b0001011;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ex_valid_i;
  logic [31:0] pc_i;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [6:0]  funct7_i;
  logic [4:0]  rd_i;
  logic [31:0] alu_result_i, store_data_i, mul_result_i;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic        wb_reg_write_o;
  logic [31:0] wb_data_o;
  logic        misaligned_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  core_mem_stage #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ex_valid_i(ex_valid_i), .pc_i(pc_i),
    .opcode_i(opcode_i), .funct3_i(funct3_i), .funct7_i(funct7_i), .rd_i(rd_i),
    .alu_result_i(alu_result_i), .store_data_i(store_data_i),
    .mul_result_i(mul_result_i), .stall_o(stall_o), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_reg_write_o(wb_reg_write_o),
    .wb_data_o(wb_data_o), .misaligned_o(misaligned_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen at +3.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic scramble_ex();
    ex_valid_i   = 1'($urandom);
    pc_i         = $urandom;
    opcode_i     = 7'($urandom);
    funct3_i     = 3'($urandom);
    funct7_i     = 7'($urandom);
    rd_i         = 5'($urandom);
    alu_result_i = $urandom;
    store_data_i = $urandom;
    mul_result_i = $urandom;
  endtask

  task automatic drive_bubble();
    scramble_ex();
    ex_valid_i    = 1'b0;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = $urandom;
  endtask

  function automatic logic ref_writes(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_LUI) ||
           (op == OP_AUIPC) || (op == OP_JAL) || (op == OP_JALR) || (op == OP_PIM);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rdata);
    logic [31:0] shifted;
    logic [31:0] v;
    shifted = rdata >> (8 * (addr % 4));
    case (f3)
      3'd0: begin v = shifted % 256;   return (v >= 128)   ? v - 32'd256   : v; end
      3'd4: return shifted % 256;
      3'd1: begin v = shifted % 65536; return (v >= 32768) ? v - 32'd65536 : v; end
      3'd5: return shifted % 65536;
      default: return rdata;
    endcase
  endfunction

  function automatic logic ref_misaligned(input bit is_st, input logic [2:0] f3,
                                          input logic [31:0] addr);
    int size;
    if (is_st && f3 >= 3) return 1'b1;
    if (!is_st && (f3 == 3 || f3 == 6 || f3 == 7)) return 1'b1;
    size = 1 << (f3 % 4);
    return (addr % size) != 0;
  endfunction

  task automatic check_wb(input string tag, input logic exp_write, input logic [4:0] exp_rd,
                          input logic [31:0] exp_data, input logic exp_mis);
    chk({tag, " wb_valid"}, 32'(wb_valid_o), 32'd1);
    chk({tag, " reg_write"}, 32'(wb_reg_write_o), 32'(exp_write));
    chk({tag, " misaligned"}, 32'(misaligned_o), 32'(exp_mis));
    if (exp_write) begin
      chk({tag, " wb_rd"}, 32'(wb_rd_o), 32'(exp_rd));
      chk({tag, " wb_data"}, wb_data_o, exp_data);
    end
  endtask

  task automatic bubble_and_check(input string tag, input logic exp_write,
                                  input logic [4:0] exp_rd, input logic [31:0] exp_data,
                                  input logic exp_mis);
    tick();
    drive_bubble();
    #2;
    chk({tag, " bubble stall"}, 32'(stall_o), 32'd0);
    chk({tag, " bubble req"}, 32'(dmem_req_o), 32'd0);
    check_wb(tag, exp_write, exp_rd, exp_data, exp_mis);
  endtask

  task automatic mem_op(input string tag, input bit is_st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] rd, input int gdly, input int rdly,
                        input logic [31:0] rdata);
    logic        mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_addr;
    mis       = ref_misaligned(is_st, f3, addr);
    exp_addr  = addr - (addr % 4);
    exp_be    = 4'hF;
    exp_wdata = sdata;
    if (f3 % 4 == 0) begin
      exp_be    = 4'(1 << (addr % 4));
      exp_wdata = (sdata % 256) * 32'h01010101;
    end else if (f3 % 4 == 1) begin
      exp_be    = 4'(3 << (addr % 4));
      exp_wdata = (sdata % 65536) * 32'h00010001;
    end

    chk({tag, " prior wb_valid"}, 32'(wb_valid_o), 32'd0);
    ex_valid_i    = 1'b1;
    opcode_i      = is_st ? OP_STORE : OP_LOAD;
    funct3_i      = f3;
    funct7_i      = 7'($urandom);
    rd_i          = rd;
    alu_result_i  = addr;
    store_data_i  = sdata;
    pc_i          = $urandom;
    mul_result_i  = $urandom;
    dmem_gnt_i    = (gdly == 0);
    dmem_rvalid_i = 1'b0;
    #2;
    if (mis) begin
      chk({tag, " mis req"}, 32'(dmem_req_o), 32'd0);
      chk({tag, " mis stall"}, 32'(stall_o), 32'd0);
      bubble_and_check(tag, 1'b0, rd, 32'd0, 1'b1);
      return;
    end
    chk({tag, " req"}, 32'(dmem_req_o), 32'd1);
    chk({tag, " we"}, 32'(dmem_we_o), 32'(is_st));
    chk({tag, " addr"}, dmem_addr_o, exp_addr);
    if (is_st) begin
      chk({tag, " be"}, 32'(dmem_be_o), 32'(exp_be));
      chk({tag, " wdata"}, dmem_wdata_o, exp_wdata);
    end
    chk({tag, " stall"}, 32'(stall_o), 32'(!(is_st && gdly == 0)));

    for (int i = 1; i <= gdly; i++) begin
      tick();
      scramble_ex();
      dmem_gnt_i    = (i == gdly);
      dmem_rvalid_i = 1'($urandom);
      dmem_rdata_i  = $urandom;
      #2;
      chk({tag, " held req"}, 32'(dmem_req_o), 32'd1);
      chk({tag, " held addr"}, dmem_addr_o, exp_addr);
      chk({tag, " held we"}, 32'(dmem_we_o), 32'(is_st));
      if (is_st) begin
        chk({tag, " held be"}, 32'(dmem_be_o), 32'(exp_be));
        chk({tag, " held wdata"}, dmem_wdata_o, exp_wdata);
      end
      chk({tag, " gnt-wait stall"}, 32'(stall_o), 32'(!(is_st && i == gdly)));
    end

    if (!is_st) begin
      for (int j = 0; j <= rdly; j++) begin
        tick();
        scramble_ex();
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = (j == rdly);
        dmem_rdata_i  = (j == rdly) ? rdata : $urandom;
        #2;
        chk({tag, " rvalid-wait req"}, 32'(dmem_req_o), 32'd0);
        chk({tag, " rvalid-wait stall"}, 32'(stall_o), 32'(j != rdly));
      end
    end
    bubble_and_check(tag, !is_st && rd != 5'd0, rd, ref_load(f3, addr, rdata), 1'b0);
  endtask

  task automatic alu_op(input string tag, input logic [6:0] op, input logic [6:0] f7,
                        input logic [4:0] rd, input logic [31:0] pc,
                        input logic [31:0] alu, input logic [31:0] mul);
    logic [31:0] exp_data;
    if (op == OP_JAL || op == OP_JALR) exp_data = pc + 32'd4;
    else if (op == OP_R && f7 == 7'd1)  exp_data = mul;
    else                                exp_data = alu;
    chk({tag, " prior wb_valid"}, 32'(wb_valid_o), 32'd0);
    ex_valid_i    = 1'b1;
    opcode_i      = op;
    funct3_i      = 3'($urandom);
    funct7_i      = f7;
    rd_i          = rd;
    pc_i          = pc;
    alu_result_i  = alu;
    store_data_i  = $urandom;
    mul_result_i  = mul;
    dmem_gnt_i    = 1'($urandom);
    dmem_rvalid_i = 1'($urandom);
    #2;
    chk({tag, " stall"}, 32'(stall_o), 32'd0);
    chk({tag, " req"}, 32'(dmem_req_o), 32'd0);
    bubble_and_check(tag, ref_writes(op) && rd != 5'd0, rd, exp_data, 1'b0);
  endtask

  initial begin
    logic [6:0] ops [8];
    ops = '{OP_R, OP_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_PIM};

    rst_i = 1'b1;
    drive_bubble();
    tick();
    tick();
    chk("reset wb_valid", 32'(wb_valid_o), 32'd0);
    chk("reset reg_write", 32'(wb_reg_write_o), 32'd0);
    chk("reset misaligned", 32'(misaligned_o), 32'd0);
    chk("reset wb_data", wb_data_o, 32'd0);
    chk("reset wb_rd", 32'(wb_rd_o), 32'd0);
    chk("reset req", 32'(dmem_req_o), 32'd0);
    rst_i = 1'b0;
    tick();

    mem_op("SW 0x100", 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 5'd3, 0, 0, 32'd0);
    tick();
    mem_op("SB 0x203", 1'b1, 3'd0, 32'h203, 32'h000000A5, 5'd0, 0, 0, 32'd0);
    tick();
    mem_op("LB 0x102", 1'b0, 3'd0, 32'h102, 32'd0, 5'd7, 0, 0, 32'h1280FF34);
    tick();
    mem_op("LBU 0x102", 1'b0, 3'd4, 32'h102, 32'd0, 5'd8, 0, 0, 32'h1280FF34);
    tick();
    mem_op("LH 0x101", 1'b0, 3'd1, 32'h101, 32'd0, 5'd9, 0, 0, 32'd0);
    tick();
    mem_op("LW slow", 1'b0, 3'd2, 32'h400, 32'd0, 5'd10, 3, 1, 32'hCAFEF00D);
    tick();
    mem_op("SH slow", 1'b1, 3'd1, 32'h52, 32'h1234ABCD, 5'd4, 2, 0, 32'd0);
    tick();

    // Reset while waiting for load data; the late rvalid must not retire.
    ex_valid_i = 1'b1; opcode_i = OP_LOAD; funct3_i = 3'd2; rd_i = 5'd11;
    alu_result_i = 32'h300; dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b0;
    tick();
    drive_bubble();
    #2;
    chk("rstmid stall", 32'(stall_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("rstmid stall", 32'(stall_o), 32'd0);
    chk("rstmid req", 32'(dmem_req_o), 32'd0);
    chk("rstmid wb_valid", 32'(wb_valid_o), 32'd0);
    tick();
    rst_i = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h55AA55AA;
    #2;
    chk("late rvalid stall", 32'(stall_o), 32'd0);
    tick();
    dmem_rvalid_i = 1'b0;
    #2;
    chk("late rvalid wb_valid", 32'(wb_valid_o), 32'd0);
    chk("late rvalid reg_write", 32'(wb_reg_write_o), 32'd0);
    tick();

    alu_op("MUL rd5", OP_R, 7'd1, 5'd5, 32'h0, 32'h11111111, 32'h87654321);
    tick();
    alu_op("JAL pc40", OP_JAL, 7'd0, 5'd1, 32'h40, 32'h0, 32'h0);
    tick();
    alu_op("ADD rd0", OP_R, 7'd0, 5'd0, 32'h0, 32'h9, 32'h0);
    tick();
    alu_op("BRANCH", OP_BRANCH, 7'd0, 5'd6, 32'h80, 32'h1, 32'h0);
    tick();

    for (int n = 0; n < 60; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      if (kind < 2) begin
        mem_op(kind == 1 ? "rand store" : "rand load", kind == 1, 3'($urandom),
               $urandom, $urandom, 5'($urandom), $urandom_range(0, 3),
               $urandom_range(0, 2), $urandom);
      end else begin
        alu_op("rand alu", ops[$urandom_range(0, 7)],
               ($urandom_range(0, 1) == 1) ? 7'd1 : 7'($urandom),
               5'($urandom), $urandom, $urandom, $urandom);
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
